// File: rtl/hls_cnn_2d_100s_mac_pipe_if.sv
// Handshake bundle for the pipelined signed MAC. The input beat stream and the
// result stream share one interface. The master drives beats and accepts results.
`timescale 1ns/1ps
interface hls_cnn_2d_100s_mac_pipe_if #(
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 12,
  parameter int DOUT_WIDTH = 16
);
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DIN0_WIDTH-1:0] din0;
  logic signed [DIN1_WIDTH-1:0] din1;
  logic                         in_first;
  logic                         in_last;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DOUT_WIDTH-1:0] dout;
  logic                         dout_sat;

  modport master (
    output in_valid, din0, din1, in_first, in_last, out_ready,
    input  in_ready, out_valid, dout, dout_sat
  );

  modport slave (
    input  in_valid, din0, din1, in_first, in_last, out_ready,
    output in_ready, out_valid, dout, dout_sat
  );
endinterface

// File: rtl/hls_cnn_2d_100s_mac_pipe.sv
// Pipelined signed multiply-accumulate with framed beats. It produces one rounded,
// saturated result per first..last sequence. A single advance signal stalls everything.
`timescale 1ns/1ps
module hls_cnn_2d_100s_mac_pipe #(
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 12,
  parameter int ACC_WIDTH  = 32,
  parameter int DOUT_WIDTH = 16,
  parameter int NUM_STAGE  = 2,
  parameter int SHIFT      = 10
) (
  input logic                          ap_clk,
  input logic                          ap_rst_n,
  hls_cnn_2d_100s_mac_pipe_if.slave    bus
);
  localparam int PW = DIN0_WIDTH + DIN1_WIDTH;
  localparam int LS = NUM_STAGE - 1;
  // The rounding constant is 2^(SHIFT-1). It reduces to 0 when SHIFT is 0.
  localparam logic [ACC_WIDTH:0] RND = ((ACC_WIDTH+1)'(1) << SHIFT) >> 1;

  logic adv;
  logic signed [PW-1:0] op0, op1, prod;

  logic signed [PW-1:0] prod_q [NUM_STAGE];
  logic [NUM_STAGE-1:0] vld_q, first_q, last_q;

  logic signed [ACC_WIDTH-1:0] acc_q, prod_ext, acc_next;
  logic [ACC_WIDTH:0]          rsum;
  logic signed [ACC_WIDTH:0]   r;
  logic [ACC_WIDTH-DOUT_WIDTH+1:0] r_top;
  logic                        ovf, fire, fire_last;
  logic [DOUT_WIDTH-1:0]       res;

  logic                        out_valid_q, dout_sat_q;
  logic [DOUT_WIDTH-1:0]       dout_q;

  assign adv          = !out_valid_q || bus.out_ready;
  assign bus.in_ready = adv;

  assign op0  = PW'(bus.din0);
  assign op1  = PW'(bus.din1);
  assign prod = op0 * op1;

  // Control flags of the pipeline stages carry the reset. A bubble enters as valid=0.
  // NOTE: every sequential block uses non-blocking assignments. Each stage then reads the value its predecessor held before the edge.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
    end else if (adv) begin
      vld_q[0]   <= bus.in_valid;
      first_q[0] <= bus.in_first;
      last_q[0]  <= bus.in_last;
      for (int i = 1; i < NUM_STAGE; i++) begin
        vld_q[i]   <= vld_q[i-1];
        first_q[i] <= first_q[i-1];
        last_q[i]  <= last_q[i-1];
      end
    end
  end

  // NOTE: the product data path has no reset. Its contents are ignored until the stage valid qualifies them, so a reset would only add fan-out.
  always_ff @(posedge ap_clk) begin
    if (adv) begin
      prod_q[0] <= prod;
      for (int i = 1; i < NUM_STAGE; i++) prod_q[i] <= prod_q[i-1];
    end
  end

  assign fire      = adv && vld_q[LS];
  assign fire_last = fire && last_q[LS];

  // NOTE: each always_comb signal gets a default first, so no path can infer a latch.
  always_comb begin
    prod_ext = ACC_WIDTH'(prod_q[LS]);
    acc_next = first_q[LS] ? prod_ext : acc_q + prod_ext;
    // The extra top bit keeps the rounding add from wrapping before the shift.
    rsum     = {acc_next[ACC_WIDTH-1], acc_next} + RND;
    r        = $signed(rsum) >>> SHIFT;
    r_top    = r[ACC_WIDTH:DOUT_WIDTH-1];
    ovf      = !((&r_top) || !(|r_top));
    res      = r[DOUT_WIDTH-1:0];
    if (ovf) res = r[ACC_WIDTH] ? {1'b1, {(DOUT_WIDTH-1){1'b0}}}
                                : {1'b0, {(DOUT_WIDTH-1){1'b1}}};
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      dout_sat_q  <= 1'b0;
    end else begin
      if (fire) acc_q <= acc_next;
      // A consume and a new load on the same edge leave out_valid high with the new data.
      if (adv) out_valid_q <= fire_last;
      if (fire_last) begin
        dout_q     <= res;
        dout_sat_q <= ovf;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.dout_sat  = dout_sat_q;
endmodule
